// File: rtl/i2c_slave_datapath.sv
// I2C slave byte engine: synchronized SCL/SDA, start/stop detect, address match, byte RX/TX with ACK phases.
// Latency: pin changes act 3 cycles later; sda_o and pulses update one cycle after the triggering SCL edge.
// Backpressure: none; the master owns bus timing, rx_ack_i selects ACK/NACK for each received byte.
module i2c_slave_datapath (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic [6:0] own_addr_i,
    input  logic [7:0] tx_data_i,
    input  logic       rx_ack_i,
    output logic       sda_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_load_o,
    output logic       addr_match_o,
    output logic       rw_o,
    output logic       busy_o,
    output logic       nack_o
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] scl_sync_q, scl_sync_d;
    logic [2:0] sda_sync_q, sda_sync_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       ack_q, ack_d;
    logic       sda_q, sda_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       addr_match_q, addr_match_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic       nack_q, nack_d;

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    // [1:0] is the synchronizer pair, [2] the history flop used for edge detection
    assign scl_sync_d = {scl_sync_q[1:0], scl_i};
    assign sda_sync_d = {sda_sync_q[1:0], sda_i};
    assign scl_s      = scl_sync_q[1];
    assign scl_h      = scl_sync_q[2];
    assign sda_s      = sda_sync_q[1];
    assign sda_h      = sda_sync_q[2];
    assign scl_rise   = scl_s & ~scl_h;
    assign scl_fall   = ~scl_s & scl_h;
    assign start_det  = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det   = scl_s & scl_h & ~sda_h & sda_s;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_done_d  = byte_done_q;
        ack_d        = ack_q;
        sda_d        = sda_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        tx_load_d    = 1'b0;
        addr_match_d = addr_match_q;
        rw_d         = rw_q;
        busy_d       = busy_q;
        nack_d       = 1'b0;

        if (start_det) begin
            state_d      = ADDR;
            bit_cnt_d    = 3'd7;
            byte_done_d  = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b1;
            sda_d        = 1'b1;
        end else if (stop_det) begin
            state_d      = IDLE;
            byte_done_d  = 1'b0;
            addr_match_d = 1'b0;
            busy_d       = 1'b0;
            sda_d        = 1'b1;
        end else begin
            case (state_q)
                ADDR, RX_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                        if (bit_cnt_q == 3'd0) byte_done_d = 1'b1;
                        else                   bit_cnt_d   = bit_cnt_q - 3'd1;
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        if (state_q == RX_DATA) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_d      = rx_ack_i;
                            ack_d      = rx_ack_i;
                            state_d    = RX_ACK;
                        end else if (shift_q[7:1] == own_addr_i) begin
                            sda_d        = 1'b0;
                            addr_match_d = 1'b1;
                            rw_d         = shift_q[0];
                            state_d      = ADDR_ACK;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd7;
                        if (rw_q) begin
                            shift_d   = tx_data_i;
                            tx_load_d = 1'b1;
                            sda_d     = tx_data_i[7];
                            state_d   = TX_DATA;
                        end else begin
                            sda_d   = 1'b1;
                            state_d = RX_DATA;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        sda_d     = 1'b1;
                        bit_cnt_d = 3'd7;
                        state_d   = ack_q ? WAIT_STOP : RX_DATA;
                    end
                end
                TX_DATA: begin
                    // shift_q[7] is on the bus; each fall moves the next bit up
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_d   = 1'b1;
                            state_d = TX_ACK;
                        end else begin
                            sda_d     = shift_q[6];
                            shift_d   = {shift_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            nack_d  = 1'b1;
                            state_d = WAIT_STOP;
                        end else begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        bit_cnt_d   = 3'd7;
                        shift_d     = tx_data_i;
                        tx_load_d   = 1'b1;
                        sda_d       = tx_data_i[7];
                        state_d     = TX_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i2c_core_clock_i) begin
        if (reset_bit_i) begin
            state_q      <= IDLE;
            scl_sync_q   <= 3'b111;
            sda_sync_q   <= 3'b111;
            bit_cnt_q    <= 3'd7;
            shift_q      <= 8'h00;
            byte_done_q  <= 1'b0;
            ack_q        <= 1'b0;
            sda_q        <= 1'b1;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            tx_load_q    <= 1'b0;
            addr_match_q <= 1'b0;
            rw_q         <= 1'b0;
            busy_q       <= 1'b0;
            nack_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_done_q  <= byte_done_d;
            ack_q        <= ack_d;
            sda_q        <= sda_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            tx_load_q    <= tx_load_d;
            addr_match_q <= addr_match_d;
            rw_q         <= rw_d;
            busy_q       <= busy_d;
            nack_q       <= nack_d;
        end
    end

    assign sda_o        = sda_q;
    assign rx_data_o    = rx_data_q;
    assign rx_valid_o   = rx_valid_q;
    assign tx_load_o    = tx_load_q;
    assign addr_match_o = addr_match_q;
    assign rw_o         = rw_q;
    assign busy_o       = busy_q;
    assign nack_o       = nack_q;
endmodule

// File: tb/tb_i2c_slave_datapath.sv
// Bench for i2c_slave_datapath: a bit-level I2C master drives a wired-AND bus shared with the slave.
// Table vectors, hand-written corner sequences and random transactions checked against a byte-level model.
module tb_i2c_slave_datapath;
    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic [6:0] own_addr;
    logic [7:0] tx_data;
    logic       rx_ack;
    logic       sda_o, rx_valid_o, tx_load_o, addr_match_o, rw_o, busy_o, nack_o;
    logic [7:0] rx_data_o;
    logic       sda_bus;

    int errors = 0;
    int checks = 0;

    // pulse-cycle counters, written only by the monitor
    int   rxv_cnt = 0, txl_cnt = 0, nack_cnt = 0, sda_low_cnt = 0;
    logic [7:0] rx_last = 8'h00;

    assign sda_bus = sda_m & sda_o;

    always #5 clk = ~clk;

    i2c_slave_datapath dut (
        .i2c_core_clock_i (clk),
        .reset_bit_i      (rst),
        .scl_i            (scl_m),
        .sda_i            (sda_bus),
        .own_addr_i       (own_addr),
        .tx_data_i        (tx_data),
        .rx_ack_i         (rx_ack),
        .sda_o            (sda_o),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .tx_load_o        (tx_load_o),
        .addr_match_o     (addr_match_o),
        .rw_o             (rw_o),
        .busy_o           (busy_o),
        .nack_o           (nack_o)
    );

    always @(negedge clk) begin
        if (rx_valid_o) begin
            rxv_cnt = rxv_cnt + 1;
            rx_last = rx_data_o;
        end
        if (tx_load_o) txl_cnt = txl_cnt + 1;
        if (nack_o)    nack_cnt = nack_cnt + 1;
        if (!sda_o)    sda_low_cnt = sda_low_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic seen);
        sda_m = b;
        tick(5);
        scl_m = 1'b1;
        tick(5);
        seen = sda_bus;
        tick(5);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic do_start();
        sda_m = 1'b1;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b0;
        tick(10);
        scl_m = 1'b0;
        tick(5);
    endtask

    task automatic do_stop();
        sda_m = 1'b0;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        sda_m = 1'b1;
        tick(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(b[i], dummy);
        send_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) send_bit(1'b1, b[i]);
        send_bit(master_ack, dummy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " sda_o"},        {31'd0, sda_o},        32'd1);
        check({tag, " rx_data_o"},    {24'd0, rx_data_o},    32'd0);
        check({tag, " rx_valid_o"},   {31'd0, rx_valid_o},   32'd0);
        check({tag, " tx_load_o"},    {31'd0, tx_load_o},    32'd0);
        check({tag, " addr_match_o"}, {31'd0, addr_match_o}, 32'd0);
        check({tag, " rw_o"},         {31'd0, rw_o},         32'd0);
        check({tag, " busy_o"},       {31'd0, busy_o},       32'd0);
        check({tag, " nack_o"},       {31'd0, nack_o},       32'd0);
    endtask

    typedef struct {
        logic [6:0] own;
        logic [7:0] addr;
        logic [7:0] d0;
        logic       ack0;
        logic [7:0] d1;
        logic       e_aack;
        logic       e_ack0;
        logic       e_ack1;
        int         e_valids;
        logic [7:0] e_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       a, a0, a1, dummy;
        logic [7:0] rb;
        int         rxv0, txl0, nk0, low0;

        vecs[0] = '{7'h3A, 8'h74, 8'hA5, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 2, 8'h5A};
        vecs[1] = '{7'h3A, 8'h44, 8'h12, 1'b0, 8'h34, 1'b1, 1'b1, 1'b1, 0, 8'h00};
        vecs[2] = '{7'h3A, 8'h74, 8'h33, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1, 8'h33};
        vecs[3] = '{7'h7F, 8'hFE, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 2, 8'hFF};
        vecs[4] = '{7'h01, 8'h02, 8'hC9, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 2, 8'h3C};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        own_addr = 7'h3A; tx_data = 8'h00; rx_ack = 1'b0;
        tick(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(5);

        // table: write transactions of address + two data bytes
        foreach (vecs[k]) begin
            own_addr = vecs[k].own;
            rxv0 = rxv_cnt; low0 = sda_low_cnt;
            do_start();
            check($sformatf("v%0d busy after start", k), {31'd0, busy_o}, 32'd1);
            write_byte(vecs[k].addr, a);
            check($sformatf("v%0d addr ack", k), {31'd0, a}, {31'd0, vecs[k].e_aack});
            check($sformatf("v%0d addr_match", k), {31'd0, addr_match_o}, {31'd0, ~vecs[k].e_aack});
            rx_ack = vecs[k].ack0;
            write_byte(vecs[k].d0, a0);
            rx_ack = 1'b0;
            write_byte(vecs[k].d1, a1);
            do_stop();
            check($sformatf("v%0d ack0", k), {31'd0, a0}, {31'd0, vecs[k].e_ack0});
            check($sformatf("v%0d ack1", k), {31'd0, a1}, {31'd0, vecs[k].e_ack1});
            check($sformatf("v%0d rx_valid cycles", k), rxv_cnt - rxv0, vecs[k].e_valids);
            if (vecs[k].e_valids > 0)
                check($sformatf("v%0d rx_data", k), {24'd0, rx_last}, {24'd0, vecs[k].e_last});
            if (vecs[k].e_aack)
                check($sformatf("v%0d sda low cycles", k), sda_low_cnt - low0, 0);
            check($sformatf("v%0d busy after stop", k), {31'd0, busy_o}, 32'd0);
            check($sformatf("v%0d addr_match after stop", k), {31'd0, addr_match_o}, 32'd0);
        end

        // read 0xC3 twice, master ACK then NACK, then further clocks are ignored
        own_addr = 7'h3A; tx_data = 8'hC3;
        txl0 = txl_cnt; nk0 = nack_cnt;
        do_start();
        write_byte(8'h75, a);
        check("rd addr ack", {31'd0, a}, 32'd0);
        check("rd rw_o", {31'd0, rw_o}, 32'd1);
        check("rd addr_match", {31'd0, addr_match_o}, 32'd1);
        read_byte(1'b0, rb);
        check("rd byte0", {24'd0, rb}, 32'hC3);
        read_byte(1'b1, rb);
        check("rd byte1", {24'd0, rb}, 32'hC3);
        check("rd tx_load cycles", txl_cnt - txl0, 2);
        check("rd nack cycles", nack_cnt - nk0, 1);
        low0 = sda_low_cnt;
        tx_data = 8'h00;
        for (int i = 0; i < 9; i++) send_bit(1'b1, dummy);
        check("rd wait_stop sda low cycles", sda_low_cnt - low0, 0);
        check("rd wait_stop tx_load cycles", txl_cnt - txl0, 2);
        do_stop();
        check("rd busy after stop", {31'd0, busy_o}, 32'd0);

        // repeated start after a write address ACK, then read address
        tx_data = 8'h5E;
        do_start();
        write_byte(8'h74, a);
        check("rs first ack", {31'd0, a}, 32'd0);
        check("rs first rw_o", {31'd0, rw_o}, 32'd0);
        do_start();
        check("rs addr_match cleared", {31'd0, addr_match_o}, 32'd0);
        check("rs busy", {31'd0, busy_o}, 32'd1);
        write_byte(8'h75, a);
        check("rs second ack", {31'd0, a}, 32'd0);
        check("rs second rw_o", {31'd0, rw_o}, 32'd1);
        read_byte(1'b1, rb);
        check("rs read byte", {24'd0, rb}, 32'h5E);
        do_stop();

        // reset while driving a 0 data bit
        tx_data = 8'h00;
        do_start();
        write_byte(8'h75, a);
        sda_m = 1'b1;
        tick(5);
        check("mid-tx sda driven low", {31'd0, sda_o}, 32'd0);
        rst = 1'b1;
        tick(1);
        check_reset_outputs("mid-tx reset");
        rst = 1'b0;
        low0 = sda_low_cnt; txl0 = txl_cnt;
        tick(5);
        scl_m = 1'b1;
        tick(10);
        scl_m = 1'b0;
        tick(5);
        for (int i = 0; i < 9; i++) send_bit(1'b1, dummy);
        check("post-reset sda low cycles", sda_low_cnt - low0, 0);
        check("post-reset busy", {31'd0, busy_o}, 32'd0);
        check("post-reset tx_load cycles", txl_cnt - txl0, 0);
        do_stop();

        // random transactions against a byte-level model
        for (int t = 0; t < 24; t++) begin
            logic [7:0] addr, d;
            logic       matched, nacked, ra, eack;
            int         nbytes, exp_v;
            logic [7:0] exp_last;
            own_addr = 7'($urandom);
            addr = ($urandom_range(0, 1) == 1) ? {own_addr, 1'($urandom)} : 8'($urandom);
            matched = (addr[7:1] == own_addr);
            nbytes = $urandom_range(1, 3);
            tx_data = 8'($urandom);
            rxv0 = rxv_cnt; txl0 = txl_cnt; nk0 = nack_cnt;
            do_start();
            write_byte(addr, a);
            check($sformatf("r%0d addr ack", t), {31'd0, a}, {31'd0, ~matched});
            if (matched)
                check($sformatf("r%0d rw_o", t), {31'd0, rw_o}, {31'd0, addr[0]});
            if (addr[0]) begin
                for (int b = 0; b < nbytes; b++) begin
                    read_byte(b == nbytes - 1, rb);
                    check($sformatf("r%0d rd byte%0d", t, b), {24'd0, rb},
                          {24'd0, matched ? tx_data : 8'hFF});
                end
                check($sformatf("r%0d tx_load cycles", t), txl_cnt - txl0, matched ? nbytes : 0);
                check($sformatf("r%0d nack cycles", t), nack_cnt - nk0, matched ? 1 : 0);
            end else begin
                nacked = 1'b0; exp_v = 0; exp_last = 8'h00;
                for (int b = 0; b < nbytes; b++) begin
                    d = 8'($urandom);
                    ra = 1'($urandom);
                    rx_ack = ra;
                    write_byte(d, a);
                    eack = (matched && !nacked) ? ra : 1'b1;
                    check($sformatf("r%0d wr ack%0d", t, b), {31'd0, a}, {31'd0, eack});
                    if (matched && !nacked) begin
                        exp_v = exp_v + 1;
                        exp_last = d;
                    end
                    nacked = nacked | ra;
                end
                rx_ack = 1'b0;
                check($sformatf("r%0d rx_valid cycles", t), rxv_cnt - rxv0, exp_v);
                if (exp_v > 0)
                    check($sformatf("r%0d rx_data", t), {24'd0, rx_last}, {24'd0, exp_last});
            end
            do_stop();
            check($sformatf("r%0d busy after stop", t), {31'd0, busy_o}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/i2c_slave_datapath.md
I2C_SLAVE_DATAPATH -- requirements
Module: i2c_slave_datapath

Interface
REQ-001 SHALL have port i2c_core_clock_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have port reset_bit_i, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port scl_i, input, 1 bit: raw bus SCL, asynchronous.
REQ-004 SHALL have port sda_i, input, 1 bit: raw bus SDA, asynchronous.
REQ-005 SHALL have port own_addr_i, input, 7 bits: slave address, static during a transfer.
REQ-006 SHALL have port tx_data_i, input, 8 bits: byte to return on master read.
REQ-007 SHALL have port rx_ack_i, input, 1 bit: ACK value for received data bytes (0 = ACK, 1 = NACK).
REQ-008 SHALL have port sda_o, output, 1 bit: open-drain drive; 0 pulls low, 1 releases.
REQ-009 SHALL have port rx_data_o, output, 8 bits: last received data byte.
REQ-010 SHALL have port rx_valid_o, output, 1 bit: one-cycle pulse when rx_data_o updates.
REQ-011 SHALL have port tx_load_o, output, 1 bit: one-cycle pulse when tx_data_i is captured.
REQ-012 SHALL have port addr_match_o, output, 1 bit: high while addressed, from address ACK until stop or repeated start.
REQ-013 SHALL have port rw_o, output, 1 bit: R/W bit of the current transfer (1 = read).
REQ-014 SHALL have port busy_o, output, 1 bit: high from start detect to stop detect.
REQ-015 SHALL have port nack_o, output, 1 bit: one-cycle pulse when the master NACKs a transmitted byte.

Function
REQ-016 SHALL pass scl_i and sda_i each through a 2-flop synchronizer, plus one history flop for edge detection; any pin change SHALL be seen as an event 3 cycles later.
REQ-017 SHALL detect start as synchronized SDA falling while SCL is high, and stop as SDA rising while SCL is high.
REQ-018 SHALL give start/stop priority over any SCL edge in the same cycle.
REQ-019 SHALL implement the states IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK and WAIT_STOP.
REQ-020 SHALL respond to a start in any state (including repeated start) by going to ADDR, loading bit counter = 7, clearing addr_match_o, setting busy_o and releasing sda_o.
REQ-021 SHALL respond to a stop in any state by going to IDLE, clearing busy_o and addr_match_o, and releasing sda_o.
REQ-022 SHALL sample SDA only on synchronized SCL rising edges, MSB first, with the 3-bit counter decrementing 7 to 0.
REQ-023 SHALL change sda_o only in the cycle after a synchronized SCL falling edge.
REQ-024 ADDR SHALL capture 7 address bits plus R/W; after the 8th rising edge it SHALL compare the address with own_addr_i.
REQ-025 On address match, at the next SCL fall the block SHALL enter ADDR_ACK, drive sda_o = 0, set addr_match_o and latch rw_o.
REQ-026 On address mismatch the block SHALL enter WAIT_STOP with sda_o released; no general-call support.
REQ-027 ADDR_ACK, write (rw = 0): at the SCL fall ending the ACK bit, release sda_o and enter RX_DATA.
REQ-028 ADDR_ACK, read (rw = 1): at the SCL fall ending the ACK bit, capture tx_data_i into the shift register, pulse tx_load_o, enter TX_DATA and drive bit 7.
REQ-029 RX_DATA: after the 8th sampled bit, at the next SCL fall, update rx_data_o, pulse rx_valid_o, drive sda_o = rx_ack_i (sampled that cycle) and enter RX_ACK.
REQ-030 RX_ACK: at the next SCL fall, release sda_o; go to RX_DATA if the ACK driven was 0, else to WAIT_STOP.
REQ-031 TX_DATA: drive the next bit on each SCL fall; after the 8th bit's SCL fall, release sda_o and enter TX_ACK.
REQ-032 TX_ACK: sample SDA on SCL rise.
REQ-033 TX_ACK with SDA = 0: at the next SCL fall, reload from tx_data_i, pulse tx_load_o and go to TX_DATA.
REQ-034 TX_ACK with SDA = 1: pulse nack_o and go to WAIT_STOP with sda_o released.
REQ-035 WAIT_STOP SHALL ignore SCL edges and keep sda_o = 1 until a start or stop.
REQ-036 SHALL never change sda_o while synchronized SCL is high, except the release on start/stop.

Reset
REQ-037 While reset_bit_i is high at a clock edge, the block SHALL enter IDLE, reset all synchronizer and history flops to 1, and set the bit counter to 7.
REQ-038 Outputs under reset SHALL be: sda_o = 1, rx_data_o = 0, rx_valid_o = 0, tx_load_o = 0, addr_match_o = 0, rw_o = 0, busy_o = 0, nack_o = 0.
REQ-039 Reset asserted mid-transfer SHALL abort it within one cycle; the block SHALL stay idle until the next start.

Verification
REQ-040 own_addr = 0x3A, master writes 0x74 (write), data 0xA5, stop -> ACK low at the 9th clock; rx_data_o = 0xA5 with a one-cycle rx_valid_o; busy_o falls after stop.
REQ-041 Master writes 0x75 (read), tx_data_i = 0xC3, master ACK then NACK -> bus bits 11000011 twice; tx_load_o pulses twice; nack_o pulses once; state WAIT_STOP.
REQ-042 Address 0x22 with own_addr = 0x3A -> sda_o stays 1 throughout; addr_match_o = 0; no rx_valid_o.
REQ-043 rx_ack_i = 1 on a data byte -> sda_o = 1 during the 9th clock; further bytes are ignored until a start.
REQ-044 Repeated start after an address ACK, then read address 0x75 -> returns to ADDR; rw_o = 1; ACK driven again.
REQ-045 reset_bit_i asserted during TX_DATA while driving 0 -> next cycle sda_o = 1 and all outputs at reset values.
